// File: rtl/sdram_responder.sv
// SDRAM device emulator: decodes nRAS/nCAS/nWE commands, serves burst-1 reads after CAS latency from on-chip RAM.
// Define SDRAM_RESP_TIMING_CHECK_EN to add per-bank tRCD/tRP/tRC/tWR checking.
module sdram_responder #(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_WIDTH  = 13,
    parameter int COL_WIDTH  = 8,
    parameter int BANK_WIDTH = 2,
    parameter int MEM_AW     = 12,
    parameter int T_RCD      = 1,
    parameter int T_RP       = 1,
    parameter int T_RC       = 4,
    parameter int T_WR       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sdram_ncs,
    input  logic                    sdram_cke,
    input  logic                    sdram_nras,
    input  logic                    sdram_ncas,
    input  logic                    sdram_nwe,
    input  logic [BANK_WIDTH-1:0]   sdram_ba,
    input  logic [ROW_WIDTH-1:0]    sdram_a,
    input  logic [DATA_WIDTH/8-1:0] sdram_dqm,
    input  logic [DATA_WIDTH-1:0]   sdram_dq_in,
    output logic [DATA_WIDTH-1:0]   sdram_dq_out,
    output logic                    sdram_dq_oe,
    output logic                    init_done,
    output logic                    err,
    output logic [2:0]              err_code,
    output logic [15:0]             refresh_cnt
);

    localparam int NB      = 1 << BANK_WIDTH;
    localparam int NBYTE   = DATA_WIDTH / 8;
    localparam int T_MAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int T_MAX_B = (T_RC > T_WR) ? T_RC : T_WR;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    // One timer width for all bank counters, wide enough to saturate above every timing parameter
    localparam int CNT_W   = $clog2(T_MAX + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] AP_WR   = (T_WR < 1) ? CNT_W'(1) : CNT_W'(T_WR);

    localparam logic [2:0] CMD_MRS = 3'b000;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;

    typedef enum logic [2:0] {ST_PWRUP, ST_PC, ST_R1, ST_R2, ST_READY} init_state_t;

    init_state_t init_state_q, init_state_d;
    logic        init_viol;

    logic       cmd_valid;
    logic [2:0] cmd;
    logic       is_mrs, is_ref, is_pre, is_act, is_wr, is_rd, any_cmd;
    logic       a10, mrs_legal;
    logic [2:0] proto_code, timing_code, viol_code;
    logic       exec_ok, exec_mrs, exec_ref, exec_pre, exec_act, exec_wr, exec_rd;

    logic [NB-1:0]        bank_active;
    logic [ROW_WIDTH-1:0] open_row [NB];
    logic [MEM_AW-1:0]    mem_addr;

    logic [2:0]      cas_q;
    logic [15:0]     refresh_cnt_q;
    logic            err_q;
    logic [2:0]      err_code_q;
    logic [2:0]      rd_v_q;
    logic [MEM_AW-1:0] rd_a_q [3];
    logic [MEM_AW-1:0] rd_src;
    logic            dq_oe_q;
    logic [DATA_WIDTH-1:0] ram_rd_q;
    logic [DATA_WIDTH-1:0] mem [1 << MEM_AW];

    assign cmd_valid = sdram_cke & ~sdram_ncs;
    assign cmd       = {sdram_nras, sdram_ncas, sdram_nwe};
    assign is_mrs    = cmd_valid && (cmd == CMD_MRS);
    assign is_ref    = cmd_valid && (cmd == CMD_REF);
    assign is_pre    = cmd_valid && (cmd == CMD_PRE);
    assign is_act    = cmd_valid && (cmd == CMD_ACT);
    assign is_wr     = cmd_valid && (cmd == CMD_WR);
    assign is_rd     = cmd_valid && (cmd == CMD_RD);
    assign any_cmd   = is_mrs | is_ref | is_pre | is_act | is_wr | is_rd;
    assign a10       = sdram_a[10];
    assign mrs_legal = ((sdram_a[6:4] == 3'd2) || (sdram_a[6:4] == 3'd3)) && (sdram_a[2:0] == 3'b000);

    // Init FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) init_state_q <= ST_PWRUP;
        else       init_state_q <= init_state_d;
    end

    // Init FSM: next state; anything but NOP or the expected step is a violation
    always_comb begin
        init_state_d = init_state_q;
        init_viol    = 1'b0;
        case (init_state_q)
            ST_PWRUP: if (is_pre && a10) init_state_d = ST_PC; else if (any_cmd) init_viol = 1'b1;
            ST_PC:    if (is_ref) init_state_d = ST_R1;        else if (any_cmd) init_viol = 1'b1;
            ST_R1:    if (is_ref) init_state_d = ST_R2;        else if (any_cmd) init_viol = 1'b1;
            ST_R2: begin
                if (is_mrs) begin
                    if (mrs_legal) init_state_d = ST_READY;
                end else if (any_cmd) begin
                    init_viol = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Init FSM: output
    always_comb begin
        init_done = (init_state_q == ST_READY);
    end

    always_comb begin
        proto_code = 3'd0;
        if (init_viol)                                         proto_code = 3'd1;
        else if (is_mrs && !mrs_legal)                         proto_code = 3'd7;
        else if (is_act && bank_active[sdram_ba])              proto_code = 3'd2;
        else if ((is_rd || is_wr) && !bank_active[sdram_ba])   proto_code = 3'd3;
        else if (is_ref && (|bank_active))                     proto_code = 3'd6;
    end

    assign exec_ok  = (proto_code == 3'd0);
    assign exec_mrs = is_mrs && exec_ok;
    assign exec_ref = is_ref && exec_ok;
    assign exec_pre = is_pre && exec_ok;
    assign exec_act = is_act && exec_ok;
    assign exec_wr  = is_wr  && exec_ok;
    assign exec_rd  = is_rd  && exec_ok;

    assign mem_addr = MEM_AW'({sdram_ba, open_row[sdram_ba], sdram_a[COL_WIDTH-1:0]});

`ifdef SDRAM_RESP_TIMING_CHECK_EN
    localparam logic [CNT_W-1:0] T_RCD_C = CNT_W'(T_RCD);
    localparam logic [CNT_W-1:0] T_RP_C  = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] T_RC_C  = CNT_W'(T_RC);
    localparam logic [CNT_W-1:0] T_WR_C  = CNT_W'(T_WR);

    logic [CNT_W-1:0] rcd_cnt [NB];
    logic [CNT_W-1:0] rc_cnt  [NB];
    logic [CNT_W-1:0] rp_cnt  [NB];
    logic [CNT_W-1:0] wr_cnt  [NB];
    logic             ref_early, pre_early;

    // A PRE that cuts write recovery short is reported with the precharge-class code
    always_comb begin
        ref_early = 1'b0;
        pre_early = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (rc_cnt[b] < T_RC_C) ref_early = 1'b1;
            if ((a10 || (sdram_ba == BANK_WIDTH'(b))) && (wr_cnt[b] < T_WR_C)) pre_early = 1'b1;
        end
    end

    always_comb begin
        timing_code = 3'd0;
        if (exec_act && ((rp_cnt[sdram_ba] < T_RP_C) || (rc_cnt[sdram_ba] < T_RC_C))) timing_code = 3'd5;
        else if ((exec_rd || exec_wr) && (rcd_cnt[sdram_ba] < T_RCD_C))               timing_code = 3'd4;
        else if (exec_ref && ref_early)                                                timing_code = 3'd6;
        else if (exec_pre && pre_early)                                                timing_code = 3'd5;
    end
`else
    assign timing_code = 3'd0;
`endif

    assign viol_code = (proto_code != 3'd0) ? proto_code : timing_code;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_bank
            logic                 hit;
            logic                 act_q;
            logic [ROW_WIDTH-1:0] row_q;
            logic [CNT_W-1:0]     ap_q;

            assign hit              = (sdram_ba == BANK_WIDTH'(gi));
            assign bank_active[gi]  = act_q;
            assign open_row[gi]     = row_q;

            // ap_q counts down to the edge where auto-precharge closes the bank
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    act_q <= 1'b0;
                    row_q <= '0;
                    ap_q  <= '0;
                end else begin
                    if (ap_q != '0)     ap_q  <= ap_q - CNT_ONE;
                    if (ap_q == CNT_ONE) act_q <= 1'b0;
                    if (exec_act && hit) begin
                        act_q <= 1'b1;
                        row_q <= sdram_a;
                        ap_q  <= '0;
                    end else if (exec_pre && (a10 || hit)) begin
                        act_q <= 1'b0;
                        ap_q  <= '0;
                    end else if ((exec_rd || exec_wr) && hit && a10) begin
                        ap_q  <= exec_wr ? AP_WR : CNT_ONE;
                    end
                end
            end

`ifdef SDRAM_RESP_TIMING_CHECK_EN
            logic [CNT_W-1:0] rcd_q, rc_q, rp_q, wr_q;

            assign rcd_cnt[gi] = rcd_q;
            assign rc_cnt[gi]  = rc_q;
            assign rp_cnt[gi]  = rp_q;
            assign wr_cnt[gi]  = wr_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rcd_q <= CNT_MAX;
                    rc_q  <= CNT_MAX;
                    rp_q  <= CNT_MAX;
                    wr_q  <= CNT_MAX;
                end else begin
                    if (exec_act && hit)        rcd_q <= CNT_ONE;
                    else if (rcd_q != CNT_MAX)  rcd_q <= rcd_q + CNT_ONE;
                    if ((exec_act && hit) || exec_ref) rc_q <= CNT_ONE;
                    else if (rc_q != CNT_MAX)          rc_q <= rc_q + CNT_ONE;
                    if ((exec_pre && (a10 || hit)) || (ap_q == CNT_ONE)) rp_q <= CNT_ONE;
                    else if (rp_q != CNT_MAX)                            rp_q <= rp_q + CNT_ONE;
                    if (exec_wr && hit)        wr_q <= CNT_ONE;
                    else if (wr_q != CNT_MAX)  wr_q <= wr_q + CNT_ONE;
                end
            end
`endif
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cas_q         <= 3'd2;
            refresh_cnt_q <= '0;
            err_q         <= 1'b0;
            err_code_q    <= 3'd0;
            rd_v_q        <= '0;
            dq_oe_q       <= 1'b0;
        end else begin
            if (exec_mrs) cas_q <= sdram_a[6:4];
            if (exec_ref && (refresh_cnt_q != 16'hFFFF)) refresh_cnt_q <= refresh_cnt_q + 16'd1;
            if ((viol_code != 3'd0) && !err_q) begin
                err_q      <= 1'b1;
                err_code_q <= viol_code;
            end
            rd_v_q  <= {rd_v_q[1:0], exec_rd};
            dq_oe_q <= (cas_q == 3'd2) ? rd_v_q[1] : rd_v_q[2];
        end
    end

    assign rd_src = (cas_q == 3'd2) ? rd_a_q[1] : rd_a_q[2];

    // Storage and read path carry no reset so contents survive a reset
    always_ff @(posedge clk) begin
        rd_a_q[0] <= mem_addr;
        rd_a_q[1] <= rd_a_q[0];
        rd_a_q[2] <= rd_a_q[1];
        ram_rd_q  <= mem[rd_src];
        if (exec_wr) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (!sdram_dqm[b]) mem[mem_addr][b*8 +: 8] <= sdram_dq_in[b*8 +: 8];
            end
        end
    end

    assign sdram_dq_oe  = dq_oe_q;
    assign sdram_dq_out = dq_oe_q ? ram_rd_q : '0;
    assign err          = err_q;
    assign err_code     = err_code_q;
    assign refresh_cnt  = refresh_cnt_q;

endmodule
